// File: rtl/seg_display_peripheral_if.sv
// Bus-side connection of the 7-segment display peripheral: chip select,
// register address, single-cycle write strobe/data and the combinational
// read-back path into the top-level read mux.
interface seg_display_peripheral_if #(
  parameter int ADDR_W = 11
);
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wrBus;
  logic              we;
  logic [7:0]        rdBus;

  modport master (
    output cs,
    output addr,
    output wrBus,
    output we,
    input  rdBus
  );

  modport slave (
    input  cs,
    input  addr,
    input  wrBus,
    input  we,
    output rdBus
  );
endinterface

// File: rtl/seg_display_peripheral.sv
// Multiplexed 4-digit 7-segment display peripheral for the dashboard board.
// Holds per-digit data registers and a control register, scans the digits
// with a prescaled tick chain, blanks the first tick of every digit slot to
// avoid ghosting, and dims the display with a 16-level PWM. The digit data
// and display mode are latched into shadow registers at each slot start so
// a CPU write never changes a digit halfway through its slot.
module seg_display_peripheral #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 312,
  parameter int ADDR_W   = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  seg_display_peripheral_if.slave bus,
  output logic [7:0]              seg,
  output logic [DIGITS-1:0]       dig
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int DIG_W   = $clog2(DIGITS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DIG_W-1:0]   DIGIT_LAST = DIG_W'(DIGITS - 1);

  logic [ADDR_W-1:0]  addr_full;
  logic [2:0]         reg_sel;
  logic               wr_en;
  logic               ctrl_clear;
  logic               run;
  logic               tick_wrap;
  logic               slot_start;
  logic               lit;

  logic [7:0]         data_q [DIGITS];
  logic [7:0]         ctrl_q;
  logic               ctrl_en;

  logic [PRESC_W-1:0] presc;
  logic [3:0]         tick_idx;
  logic [DIG_W-1:0]   digit_idx;

  logic [7:0]         shadow_data;
  logic               shadow_hex;
  logic [3:0]         shadow_bright;

  logic [6:0]         hex_seg;
  logic [7:0]         pattern;
  logic [7:0]         seg_next;
  logic [DIGITS-1:0]  dig_next;
  logic [7:0]         rd_data;
  logic               guard_active;

  assign addr_full = bus.addr;
  assign reg_sel   = 3'(addr_full);
  assign wr_en     = bus.cs & bus.we;
  assign ctrl_en   = ctrl_q[0];

  // A CTRL write that clears EN stops the scan on the very edge it lands,
  // even if that edge would otherwise advance the counters.
  assign ctrl_clear = wr_en && (reg_sel == 3'd4) && !bus.wrBus[0];
  assign run        = ctrl_en && !ctrl_clear;
  assign tick_wrap  = (presc == PRESC_LAST);
  assign slot_start = run && (presc == '0) && (tick_idx == 4'd0);

  // CPU-visible registers; reserved CTRL bits are stored as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        data_q[i] <= 8'h00;
      end
      ctrl_q <= 8'h00;
    end else if (wr_en) begin
      case (reg_sel)
        3'd0, 3'd1, 3'd2, 3'd3: data_q[reg_sel[1:0]] <= bus.wrBus;
        3'd4:                   ctrl_q <= bus.wrBus & 8'hF3;
        default:                ;
      endcase
    end
  end

  // Prescaler -> tick index -> digit index chain, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      presc     <= '0;
      tick_idx  <= 4'd0;
      digit_idx <= '0;
    end else if (tick_wrap) begin
      presc    <= '0;
      tick_idx <= tick_idx + 4'd1;
      if (tick_idx == 4'd15) begin
        digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DIG_W'(1);
      end
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Capture the digit's data and display mode once per slot to prevent tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data   <= 8'h00;
      shadow_hex    <= 1'b0;
      shadow_bright <= 4'd0;
    end else if (slot_start) begin
      shadow_data   <= data_q[digit_idx];
      shadow_hex    <= ctrl_q[1];
      shadow_bright <= ctrl_q[7:4];
    end
  end

  // Standard hex-to-7-segment decode, segment order {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = 7'h00;
    case (shadow_data[3:0])
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  end

  assign pattern = shadow_hex ? {shadow_data[7], hex_seg} : shadow_data;

  // Tick 0 of each slot is the blanking guard; ticks 1..BRIGHT light the digit.
  assign lit = run && (tick_idx != 4'd0) && (tick_idx <= shadow_bright);

  // Next drive values for the registered display outputs.
  always_comb begin
    seg_next = 8'h00;
    dig_next = '1;
    if (lit) begin
      seg_next = pattern;
      dig_next = ~(DIGITS'(1) << digit_idx);
    end
  end

  // Registered display outputs, dark out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 8'h00;
      dig <= '1;
    end else begin
      seg <= seg_next;
      dig <= dig_next;
    end
  end

  assign guard_active = ctrl_en && (tick_idx == 4'd0);

  // Read-back mux; the top-level read mux qualifies it with cs.
  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = data_q[reg_sel[1:0]];
      3'd4:                   rd_data = ctrl_q;
      3'd5:                   rd_data = {{(8 - DIG_W - 1){1'b0}}, guard_active, digit_idx};
      default:                rd_data = 8'h00;
    endcase
  end

  assign bus.rdBus = rd_data;

endmodule

// File: doc/seg_display_peripheral.md
Name: seg_display_peripheral

Overview:
- CPU-bus peripheral that drives a multiplexed 4-digit 7-segment display from the motorcycle dashboard board.
- Sits directly downstream of the bus write path, on chip-select slot 3 (address 0x1800 | 0x0800 region, currently unused). It consumes the synchronised wrBus/we/addr strobes and feeds its rdBus back into the top-level read mux.
- Provides per-digit data registers, optional hex decode, 16-level brightness PWM and a blanking guard between digits.

Parameters:
- DIGITS, 4: number of multiplexed digits; this spec fixes 4.
- TICK_DIV, 312: clk cycles per PWM tick. Must be ≥ 2.
- ADDR_W, 11: width of the peripheral address bus.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  peripheral select, active high (one-hot slot from the top-level decoder).
- addr  in  ADDR_W  register address. Only addr[2:0] is decoded; upper bits are ignored.
- wrBus  in  8  write data.
- we  in  1  single-cycle write strobe from the top-level write FSM.
- rdBus  out  8  read data, combinational from the registers.
- seg  out  8  segment drive, active high, bit order {dp,g,f,e,d,c,b,a}.
- dig  out  4  digit enables, active low; dig[0] is the rightmost digit.

Behaviour:
- Reset: all registers are synchronous, active high, and apply on a clk edge.
  - DATA0..3 = 0x00, CTRL = 0x00.
  - Tick counter, tick index and digit index = 0.
  - seg = 0x00, dig = 4'b1111.
- Register map (addr[2:0]):
  - 0-3: DATA0..3, read/write.
  - 4: CTRL, read/write. bit0 EN, bit1 HEX, bits[7:4] BRIGHT, bits[3:2] reserved (read 0).
  - 5: STATUS, read-only. bits[1:0] current digit index, bit2 = blank-guard active, other bits 0.
  - 6-7: read 0x00; writes ignored.
- Write: when cs & we are sampled high at a posedge, the register updates at that edge. Writes with cs low are ignored.
- rdBus: always reflects the register selected by addr[2:0], regardless of cs (the top-level mux qualifies it).
- Timing chain:
  - Prescaler counts 0..TICK_DIV-1. On wrap it emits a tick.
  - tick_idx counts 0..15; each tick advances it by 1. A 16-tick span is one digit slot.
  - On tick_idx wrap 15→0, digit index increments modulo 4.
- Shadow latch: at the first clk of each slot (tick_idx = 0, prescaler = 0), DATA[digit] and CTRL.HEX/BRIGHT are copied into shadow registers. CPU writes mid-slot therefore appear at the next slot; no tearing within a slot.
- Segment source:
  - HEX=0: seg pattern = shadow data verbatim.
  - HEX=1: bits[3:0] are decoded to standard 7-segment hex 0-F, and dp = data bit7. Decode: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71.
- Drive and guard:
  - tick_idx = 0 is the blank guard: seg = 0x00, dig = 1111.
  - For 1 ≤ tick_idx ≤ BRIGHT: dig drives the current digit low and seg = pattern.
  - Otherwise seg = 0x00, dig = 1111.
  - BRIGHT=0 keeps the display dark; BRIGHT=15 gives 15/16 duty.
- Output latency: seg/dig are registered, one clk after the counter state they reflect.
- EN=0:
  - Prescaler, tick_idx and digit index are held at 0.
  - seg = 0x00, dig = 1111 on the next clk.
  - Registers remain writable.
- EN 0→1: the scan starts at digit 0, slot start (shadow load on the first enabled clk).
- Reset mid-scan: outputs go dark on the reset edge; all state returns to reset values; no partial slot completes.
- Simultaneous write to CTRL clearing EN at a tick boundary: EN takes priority and counters do not advance.

Test Plan:
- Reset with DATA preloaded (write 0xFF to DATA0, then reset) → DATA0 reads 0x00; seg=0x00, dig=1111 for ≥ 64 ticks.
- Write DATA0..3 = 0x01,0x02,0x04,0x08; CTRL = 0xF1 (EN, raw, BRIGHT 15) → digit k active-low, seg = 1<<k for ticks 1..15 of slot k. Each slot is 16×TICK_DIV clks, order 0,1,2,3,0.
- CTRL = 0x13 (HEX, BRIGHT 1), DATA2 = 0x8A → in slot 2, seg=0xF7 for exactly TICK_DIV clks after a TICK_DIV-clk guard, dark for the remaining 14 ticks.
- Mid-slot write DATA1 0x3F→0x06 during digit 1's slot → seg stays 0x3F until the slot ends; the next digit-1 slot shows 0x06.
- CTRL BRIGHT=0 with EN=1 → dig=1111 throughout; STATUS digit index still cycles 0→3.
- Write CTRL=0x00 mid-slot, then 0xF1 → outputs dark one clk after the write; on re-enable, digit 0 guard is seen first. Read addr 6 → 0x00; write with cs=0 → no register change.
